// File: rtl/nibble_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_pkg
//  Description : Shared types and constants for the nibble-serial subtractor.
//                Provides the FSM state encoding, the slice width and a helper
//                that sizes the nibble index register.
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_serial_pkg;

   // Width of one arithmetic slice (a nibble).
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index register width: clog2(nib), but never narrower than one bit.
   function automatic int idx_width(input int nib);
      return (nib > 2) ? $clog2(nib) : 1;
   endfunction

endpackage : nibble_serial_pkg
`default_nettype wire

// File: rtl/nibble_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_subtractor_if
//  Description : Start/busy/done handshake and operand/result bus of the
//                nibble-serial subtractor.
//                master : drives start, a, b, b_in (and op), observes results
//                slave  : the subtractor itself
//                Optional macro SERIAL_ADD_MODE_EN adds the op select signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface nibble_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
`ifdef SERIAL_ADD_MODE_EN
   logic             op;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             ovf;

   modport master (
`ifdef SERIAL_ADD_MODE_EN
      output op,
`endif
      output start, a, b, b_in,
      input  busy, done, diff, b_out, ovf
   );

   modport slave (
`ifdef SERIAL_ADD_MODE_EN
      input  op,
`endif
      input  start, a, b, b_in,
      output busy, done, diff, b_out, ovf
   );

endinterface : nibble_serial_subtractor_if
`default_nettype wire

// File: rtl/nibble_serial_subtractor_cla.sv
`default_nettype none
// ============================================================================
//  Module      : cla_slice_4
//  Description : Purely combinational 4-bit carry-lookahead adder slice.
//                Ports: x, y (4-bit addends), ci (carry-in),
//                       s (4-bit sum), co (carry-out).
//  Revision    : 1.0  initial release
// ============================================================================
module cla_slice_4 (
   input  wire logic [3:0] x,
   input  wire logic [3:0] y,
   input  wire logic       ci,
   output logic      [3:0] s,
   output logic            co
);
   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = x & y;
   assign w_p = x ^ y;

   // Every carry is expanded directly from generate/propagate terms so no
   // carry ripples through another.
   assign w_c[0] = ci;
   assign w_c[1] = w_g[0] | (w_p[0] & ci);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & ci);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

   assign s  = w_p ^ w_c[3:0];
   assign co = w_c[4];

endmodule : cla_slice_4
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_subtractor
//  Description : Multi-cycle subtractor, diff = a - b - b_in, one nibble per
//                clock (LSB nibble first) through a single 4-bit CLA slice.
//                Ports: clk, rst_n (async, active low),
//                       bus (slave): start, a, b, b_in, [op] in;
//                                    busy, done, diff, b_out, ovf out.
//                WIDTH must be a multiple of 4 and at least 4.
//                Optional macro SERIAL_ADD_MODE_EN: op=1 selects a + b + b_in.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_subtractor
   import nibble_serial_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   nibble_serial_subtractor_if.slave bus
);
   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = idx_width(NIB);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;
   logic             r_b_out;
   logic             r_ovf;
   logic             r_op;

   logic [3:0]       w_x;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_y;
   logic [3:0]       w_s;
   logic             w_co;
   logic             w_last;
   logic             w_accept;
   logic             w_ovf;
   logic             w_b_out;

   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_idx == IDX_W'(NIB - 1));
   assign w_x      = r_a[{r_idx, 2'b00} +: NIB_W];
   assign w_b_nib  = r_b[{r_idx, 2'b00} +: NIB_W];

   // Subtraction feeds the inverted subtrahend; the initial carry (~b_in)
   // supplies the +1 of the two's complement.
   always_comb begin
      w_y     = r_op ? w_b_nib : ~w_b_nib;
      w_b_out = r_op ? w_co : ~w_co;
      if (r_op)
         w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
      else
         w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
   end

   cla_slice_4 u_slice (
      .x  (w_x),
      .y  (w_y),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_diff  <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_b_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_op    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_b_out <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_state <= RUN;
`ifdef SERIAL_ADD_MODE_EN
                  r_op    <= bus.op;
                  r_carry <= bus.op ? bus.b_in : ~bus.b_in;
`else
                  r_op    <= 1'b0;
                  r_carry <= ~bus.b_in;
`endif
               end
            end
            RUN: begin
               // Result nibbles land in place; diff is only meaningful at done.
               r_diff[{r_idx, 2'b00} +: NIB_W] <= w_s;
               r_carry <= w_co;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_b_out <= w_b_out;
                  r_ovf   <= w_ovf;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.diff  = r_diff;
   assign bus.b_out = r_b_out;
   assign bus.ovf   = r_ovf;

endmodule : nibble_serial_subtractor
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_subtractor
//  Description : Self-checking bench for nibble_serial_subtractor (WIDTH=16)
//                and its cla_slice_4 sub-module, directed vectors with
//                hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_subtractor;
   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [3:0] cx, cy, cs;
   logic       cci, cco;

   cla_slice_4 u_cla (
      .x  (cx),
      .y  (cy),
      .ci (cci),
      .s  (cs),
      .co (cco)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One accepted operation; checks latency and results, optionally the
   // done drop and hold on the following cycle.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic [15:0] ed, input logic eb, input logic eo,
                         input bit hold);
      int lat;
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.b_in  = bin;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 16'hDEAD;
      bus.b     = 16'hBEEF;
      bus.b_in  = 1'b0;
      check("busy_at_accept", 32'(bus.busy), 1);
      check("done_at_accept", 32'(bus.done), 0);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) check("busy_mid_run", 32'(bus.busy), 1);
      end
      check("latency", 32'(lat), 4);
      check("diff", 32'(bus.diff), 32'(ed));
      check("b_out", 32'(bus.b_out), 32'(eb));
      check("ovf", 32'(bus.ovf), 32'(eo));
      check("busy_at_done", 32'(bus.busy), 0);
      if (hold) begin
         @(posedge clk);
         #1;
         check("done_drop", 32'(bus.done), 0);
         check("diff_hold", 32'(bus.diff), 32'(ed));
      end
   endtask

   initial begin
      int seen;
      n_pass    = 0;
      n_total   = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.b_in  = 1'b0;
`ifdef SERIAL_ADD_MODE_EN
      bus.op    = 1'b0;
`endif

      // Exhaustive slice check: {co,s} must equal x + y + ci.
      for (int i = 0; i < 512; i++) begin
         {cci, cy, cx} = i[8:0];
         #1;
         check("cla_slice", 32'({cco, cs}), 32'(cx) + 32'(cy) + 32'(cci));
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_diff", 32'(bus.diff), 0);
      check("rst_b_out", 32'(bus.b_out), 0);
      check("rst_ovf", 32'(bus.ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0); // back-to-back
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
      run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

      // Start while busy is ignored.
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'h0001; bus.b_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.a = 16'h0000; bus.b = 16'h1111; bus.b_in = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      while (bus.done !== 1'b1 && seen < 12) begin
         @(posedge clk);
         #1;
         seen++;
      end
      check("ign_done_seen", 32'(bus.done), 1);
      check("ign_diff", 32'(bus.diff), 32'h0000_FFFE);
      check("ign_b_out", 32'(bus.b_out), 0);
      check("ign_ovf", 32'(bus.ovf), 0);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'h0001; bus.b_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_diff", 32'(bus.diff), 0);
      check("abort_b_out", 32'(bus.b_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      check("abort_no_done", 32'(seen), 0);

      run_op(16'hABCD, 16'h0BCD, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADD_MODE_EN
      bus.op = 1'b1;
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      run_op(16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
      bus.op = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_nibble_serial_subtractor
`default_nettype wire
